conv_output_packer: RTL and testbench
=====================================

Name: conv_output_packer

Overview:
- Downstream stage of matrixAccelerator. Accepts one 32-bit convolution result per cycle on cSum/cReady.
- Scales each result by an arithmetic right shift, then saturates it to an unsigned DATA_WIDTH pixel.
- Packs pixels into 32-bit AXI4-Stream words with per-line flush, tkeep and end-of-frame tlast.
- Buffers words in a FIFO to absorb m_axis backpressure, and signals a pause to Convolution_Controller before the FIFO overflows.

Parameters:
- DATA_WIDTH, 8, output pixel width; legal values 8, 16, 32. PIX_PER_WORD = 32/DATA_WIDTH (derived, not overridable).
- FIFO_DEPTH, 16, output FIFO depth in 32-bit words; power of two, >= 4.
- PAUSE_MARGIN, 4, free-entry threshold at or below which pause asserts.
- DIM_WIDTH, 16, width of the line and frame dimension counters.

Ports:
- Clk  in  1  single clock.
- Rst  in  1  synchronous, active-high reset.
- cfg_out_width  in  DIM_WIDTH  output pixels per line; latched at frame_start.
- cfg_out_height  in  DIM_WIDTH  output lines per frame; latched at frame_start.
- cfg_shift  in  5  arithmetic right-shift amount; latched at frame_start.
- frame_start  in  1  one-cycle pulse that arms the block for a new frame.
- cSum  in  32  signed convolution result.
- cReady  in  1  cSum is valid this cycle; each high cycle is one pixel.
- m_axis_data  out  32  packed pixels; first pixel in lane 0 (bits DATA_WIDTH-1:0).
- m_axis_valid  out  1  AXI4-S valid.
- m_axis_ready  in  1  AXI4-S ready.
- m_axis_keep  out  4  byte enables for valid lanes.
- m_axis_last  out  1  high on the final word of the frame.
- pause  out  1  FIFO free entries <= PAUSE_MARGIN; upstream must stop issuing results.
- busy  out  1  high in ACTIVE or DRAIN.
- frame_done  out  1  one-cycle pulse when the last word completes its handshake.
- overflow_err  out  1  sticky; a pixel was dropped.
- cfg_err  out  1  sticky; frame_start was seen with a zero dimension.

Behaviour:
- Reset values: all outputs 0. Rst also clears counters, the pack register and FIFO contents; the state returns to IDLE. A reset mid-frame discards the partial word and any queued words. Sticky flags clear only on Rst.
- State machine:
  - IDLE -> ACTIVE on frame_start when both dimensions are nonzero; the cfg_* values are latched.
  - frame_start with a zero dimension: stay in IDLE, set cfg_err.
  - ACTIVE -> DRAIN after the pixel at col = width-1, row = height-1 is packed.
  - DRAIN -> IDLE when the FIFO is empty and the last word has handshaked. frame_done pulses in the handshake cycle.
- frame_start in ACTIVE or DRAIN is ignored.
- cReady outside ACTIVE: the pixel is dropped and overflow_err is set.
- Pixel arithmetic:
  - s = $signed(cSum) >>> cfg_shift (32-bit signed).
  - s < 0 -> 0; s > 2^DATA_WIDTH-1 -> 2^DATA_WIDTH-1; otherwise s[DATA_WIDTH-1:0].
- Pipeline: the cReady cycle N registers the saturated pixel into stage 1 at edge N. The pack register updates at N+1.
- Word emission:
  - A word is pushed to the FIFO at N+2 when PIX_PER_WORD lanes are filled or the pixel is the last of a line.
  - With an empty FIFO, m_axis_valid is visible in cycle N+3.
- Line boundary: the partial word flushes with unused lanes zeroed. m_axis_keep covers only valid lanes (DATA_WIDTH/8 bytes per lane, low bytes first). Every line starts a new word.
- m_axis_last is stored alongside each FIFO entry; it is 1 only for the word holding the final pixel of the frame.
- Counters: col wraps to 0 at width-1 and increments row; row is checked against height-1.
- AXI4-S rules:
  - data, keep and last are stable while valid && !ready.
  - The FIFO pops on valid && ready.
  - A simultaneous push and pop in the same cycle is legal and leaves the occupancy count unchanged.
- pause is registered from the occupancy after the current push and pop. Upstream tolerates up to PAUSE_MARGIN-1 words of skid.
- FIFO full:
  - A word push is blocked and the word is dropped; overflow_err is set.
  - The pack register continues with the next word, so alignment and counts are preserved.

Decomposition:
- definitions.h: PACK_IDLE/PACK_ACTIVE/PACK_DRAIN state encodings and a keep-mask derivation macro.
- Sub-module sync_fifo: width 32+4+1, depth FIFO_DEPTH, first-word fall-through. It exposes a count output used to derive pause.

Test Plan:
- Baseline: width 6, height 2, shift 0, DATA_WIDTH 8; cSum 0..11 on consecutive cycles, m_axis_ready=1.
  -> words 0x03020100/keep 0xF/last 0, 0x00000504/keep 0x3/last 0, 0x09080706/keep 0xF/last 0, 0x00000B0A/keep 0x3/last 1.
  -> frame_done is a single pulse.
- Saturation and shift: shift 0 with cSum -5, 300, 128 -> 0x00, 0xFF, 0x80. shift 2 with 1020 and 400 -> 0xFF and 0x64.
- Backpressure: width 1078, m_axis_ready=0, 64 pixels sent.
  -> pause high once occupancy reaches 12 words.
  -> after ready=1, 16 words drain in order with stable data while stalled; overflow_err stays 0.
- Overflow: m_axis_ready=0, ignore pause, send 80 pixels.
  -> overflow_err=1; the first 16 words are intact; the next pixel after the dropped words lands in lane 0.
- Reset mid-frame: assert Rst for one cycle after 7 pixels.
  -> m_axis_valid=0 and busy=0 next cycle.
  -> a new frame (width 4, height 1, cSum 1..4) yields exactly 0x04030201/keep 0xF/last 1.
- Config errors and spurious input:
  - frame_start with height 0 -> cfg_err=1 and busy stays 0.
  - cReady in IDLE -> overflow_err=1 and no output word.

Source files
------------

// File: rtl/conv_output_packer_pkg.sv
// Shared types for the convolution output packer: FSM encodings, the FIFO word
// layout and the byte-enable derivation used for partial words.
package conv_output_packer_pkg;

  typedef enum logic [1:0] {
    PACK_IDLE   = 2'd0,
    PACK_ACTIVE = 2'd1,
    PACK_DRAIN  = 2'd2
  } pack_state_e;

  localparam int unsigned AXIS_WIDTH = 32;
  localparam int unsigned KEEP_WIDTH = AXIS_WIDTH / 8;

  typedef struct packed {
    logic [AXIS_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } axis_word_t;

  localparam int unsigned WORD_BITS = $bits(axis_word_t);

  // One keep bit per byte of every filled lane, lowest bytes first.
  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input int unsigned lanes,
                                                      input int unsigned bytes_per_lane);
    logic [KEEP_WIDTH:0] m;
    m = ((KEEP_WIDTH+1)'(1) << (lanes * bytes_per_lane)) - (KEEP_WIDTH+1)'(1);
    return m[KEEP_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/conv_output_packer_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible whenever
// the FIFO is non-empty. Contents are cleared on reset.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/conv_output_packer.sv
// Scales and saturates convolution results to pixels, packs them into 32-bit
// AXI4-Stream words per line, and buffers them with upstream pause control.
//
// state       | meaning
// PACK_IDLE   | waiting for frame_start with nonzero dimensions
// PACK_ACTIVE | accepting pixels until the last pixel of the frame
// PACK_DRAIN  | pipeline and FIFO emptying until the last word handshakes
module conv_output_packer
  import conv_output_packer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PAUSE_MARGIN = 4,
  parameter int DIM_WIDTH    = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DIM_WIDTH-1:0]  cfg_out_width,
  input  logic [DIM_WIDTH-1:0]  cfg_out_height,
  input  logic [4:0]            cfg_shift,
  input  logic                  frame_start,
  input  logic [31:0]           cSum,
  input  logic                  cReady,
  output logic [31:0]           m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [3:0]            m_axis_keep,
  output logic                  m_axis_last,
  output logic                  pause,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow_err,
  output logic                  cfg_err
);

  localparam int          PIX_PER_WORD   = 32 / DATA_WIDTH;
  localparam int          LANE_W         = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int          CNT_W          = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BYTES_PER_LANE = DATA_WIDTH / 8;
  localparam logic [32:0] PIX_MAX        = (33'd1 << DATA_WIDTH) - 33'd1;

  pack_state_e state_q, state_d;

  logic [DIM_WIDTH-1:0]  width_q, height_q, col_q, row_q;
  logic [4:0]            shift_q;
  logic                  cfg_ok, start_ok, accept, at_eol, at_eof;

  logic signed [31:0]    shifted;
  logic [DATA_WIDTH-1:0] pix_sat;

  logic                  s1_valid, s1_eol, s1_eof;
  logic [DATA_WIDTH-1:0] s1_pix;

  logic [31:0]           pack_data, pack_merged;
  logic [LANE_W-1:0]     lane_q;
  logic                  word_done;
  axis_word_t            out_word, head_word;
  logic                  out_valid;

  logic                  fifo_empty, fifo_full, pop_hs, push_ok;
  logic [CNT_W-1:0]      fifo_count, next_count;
  logic                  pause_q, overflow_q, cfg_err_q, last_dropped_q;

  assign cfg_ok   = (cfg_out_width != '0) && (cfg_out_height != '0);
  assign start_ok = frame_start && (state_q == PACK_IDLE) && cfg_ok;
  assign accept   = cReady && (state_q == PACK_ACTIVE);
  assign at_eol   = (col_q == width_q - DIM_WIDTH'(1));
  assign at_eof   = at_eol && (row_q == height_q - DIM_WIDTH'(1));

  always_comb begin
    shifted = $signed(cSum) >>> shift_q;
    pix_sat = shifted[DATA_WIDTH-1:0];
    if (shifted[31])                  pix_sat = '0;
    else if ({1'b0, shifted} > PIX_MAX) pix_sat = '1;
  end

  always_comb begin
    pack_merged = pack_data | (32'(s1_pix) << (32'(lane_q) * 32'(DATA_WIDTH)));
    word_done   = s1_valid && (s1_eol || (lane_q == LANE_W'(PIX_PER_WORD - 1)));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      width_q  <= '0;
      height_q <= '0;
      shift_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      if (start_ok) begin
        width_q  <= cfg_out_width;
        height_q <= cfg_out_height;
        shift_q  <= cfg_shift;
        col_q    <= '0;
        row_q    <= '0;
      end else if (accept) begin
        col_q <= at_eol ? '0 : col_q + DIM_WIDTH'(1);
        if (at_eol) row_q <= row_q + DIM_WIDTH'(1);
      end
      s1_valid <= accept;
      s1_pix   <= pix_sat;
      s1_eol   <= at_eol;
      s1_eof   <= at_eof;
    end
  end

  // Completed words sit one cycle in out_word before entering the FIFO.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pack_data <= '0;
      lane_q    <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (word_done) begin
        out_valid <= 1'b1;
        out_word  <= '{data: pack_merged,
                       keep: keep_mask(32'(lane_q) + 32'd1, BYTES_PER_LANE),
                       last: s1_eof};
        pack_data <= '0;
        lane_q    <= '0;
      end else if (s1_valid) begin
        pack_data <= pack_merged;
        lane_q    <= lane_q + LANE_W'(1);
      end
    end
  end

  assign pop_hs     = m_axis_valid && m_axis_ready;
  assign push_ok    = out_valid && (!fifo_full || pop_hs);
  assign next_count = fifo_count + CNT_W'(push_ok) - CNT_W'(pop_hs);

  sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .push      (out_valid),
    .push_data (out_word),
    .pop       (pop_hs),
    .pop_data  (head_word),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign m_axis_valid = !fifo_empty;
  assign m_axis_data  = head_word.data;
  assign m_axis_keep  = head_word.keep;
  assign m_axis_last  = head_word.last;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pause_q        <= 1'b0;
      overflow_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
      last_dropped_q <= 1'b0;
    end else begin
      pause_q <= (CNT_W'(FIFO_DEPTH) - next_count) <= CNT_W'(PAUSE_MARGIN);
      if ((cReady && !accept) || (out_valid && !push_ok)) overflow_q <= 1'b1;
      if (frame_start && (state_q == PACK_IDLE) && !cfg_ok) cfg_err_q <= 1'b1;
      // A dropped final word can never handshake, so DRAIN must exit without it.
      if (start_ok) last_dropped_q <= 1'b0;
      else if (out_valid && !push_ok && out_word.last) last_dropped_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= PACK_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      PACK_IDLE:   if (start_ok) state_d = PACK_ACTIVE;
      PACK_ACTIVE: if (accept && at_eof) state_d = PACK_DRAIN;
      PACK_DRAIN: begin
        if (pop_hs && m_axis_last) begin
          state_d    = PACK_IDLE;
          frame_done = 1'b1;
        end else if (last_dropped_q && fifo_empty && !s1_valid && !out_valid) begin
          state_d = PACK_IDLE;
        end
      end
      default:     state_d = PACK_IDLE;
    endcase
  end

  assign busy         = (state_q != PACK_IDLE);
  assign pause        = pause_q;
  assign overflow_err = overflow_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_conv_output_packer.sv
// Self-checking bench: saturation vector table plus scoreboard-checked frames,
// backpressure, overflow, reset and configuration corner cases.
module tb_conv_output_packer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] cfg_out_width, cfg_out_height;
  logic [4:0]  cfg_shift;
  logic        frame_start;
  logic [31:0] cSum;
  logic        cReady;
  logic [31:0] m_axis_data;
  logic        m_axis_valid, m_axis_ready;
  logic [3:0]  m_axis_keep;
  logic        m_axis_last, pause, busy, frame_done, overflow_err, cfg_err;

  conv_output_packer dut (
    .Clk(Clk), .Rst(Rst),
    .cfg_out_width(cfg_out_width), .cfg_out_height(cfg_out_height), .cfg_shift(cfg_shift),
    .frame_start(frame_start), .cSum(cSum), .cReady(cReady),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_keep(m_axis_keep), .m_axis_last(m_axis_last), .pause(pause), .busy(busy),
    .frame_done(frame_done), .overflow_err(overflow_err), .cfg_err(cfg_err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  typedef struct {
    logic [4:0]  shift;
    logic [31:0] csum;
    logic [7:0]  pix;
  } sat_vec_t;

  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  logic  stalled = 1'b0;
  word_t held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every handshaked word must match the next expected entry.
  always @(negedge Clk) begin
    if (Rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", {m_axis_valid, m_axis_data, m_axis_keep, m_axis_last}, {1'b1, held});
      if (m_axis_valid && m_axis_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {m_axis_data, m_axis_keep, m_axis_last}, 0);
          if ({m_axis_data, m_axis_keep, m_axis_last} == 0) begin
            errors++;
            $display("FAIL unexpected_word: got zero word expected none");
          end
        end else begin
          chk("word", {m_axis_data, m_axis_keep, m_axis_last}, exp_q.pop_front());
        end
      end
      if (frame_done) done_cnt++;
      stalled = m_axis_valid && !m_axis_ready;
      held    = '{data: m_axis_data, keep: m_axis_keep, last: m_axis_last};
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_frame(input int w, input int h, input int sh);
    cfg_out_width  = 16'(w);
    cfg_out_height = 16'(h);
    cfg_shift      = 5'(sh);
    frame_start    = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_px(input logic [31:0] v);
    cSum   = v;
    cReady = 1'b1;
    tick();
    cReady = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 500) begin tick(); n++; end
    chk({nm, "_idle"}, 64'(busy), 0);
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
    chk({nm, "_drained"}, 64'(exp_q.size()), 0);
  endtask

  task automatic pulse_rst();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  sat_vec_t sat_tab[8];

  initial begin
    int d0;
    sat_tab[0] = '{shift: 5'd0,  csum: 32'hFFFF_FFFB, pix: 8'h00};
    sat_tab[1] = '{shift: 5'd0,  csum: 32'd300,       pix: 8'hFF};
    sat_tab[2] = '{shift: 5'd0,  csum: 32'd128,       pix: 8'h80};
    sat_tab[3] = '{shift: 5'd2,  csum: 32'd1020,      pix: 8'hFF};
    sat_tab[4] = '{shift: 5'd2,  csum: 32'd400,       pix: 8'h64};
    sat_tab[5] = '{shift: 5'd8,  csum: 32'h7FFF_FFFF, pix: 8'hFF};
    sat_tab[6] = '{shift: 5'd31, csum: 32'h8000_0000, pix: 8'h00};
    sat_tab[7] = '{shift: 5'd0,  csum: 32'd255,       pix: 8'hFF};

    Rst = 1'b1; cfg_out_width = '0; cfg_out_height = '0; cfg_shift = '0;
    frame_start = 1'b0; cSum = '0; cReady = 1'b0; m_axis_ready = 1'b1;
    tick(); tick();
    chk("rst_axis", {m_axis_valid, m_axis_data, m_axis_keep, m_axis_last}, 0);
    chk("rst_status", {pause, busy, frame_done, overflow_err, cfg_err}, 0);
    Rst = 1'b0;
    tick();

    // Baseline frame 6x2
    exp_q.push_back('{data: 32'h03020100, keep: 4'hF, last: 1'b0});
    exp_q.push_back('{data: 32'h00000504, keep: 4'h3, last: 1'b0});
    exp_q.push_back('{data: 32'h09080706, keep: 4'hF, last: 1'b0});
    exp_q.push_back('{data: 32'h00000B0A, keep: 4'h3, last: 1'b1});
    d0 = done_cnt;
    start_frame(6, 2, 0);
    chk("busy_active", 64'(busy), 1);
    for (int i = 0; i < 12; i++) send_px(32'(i));
    wait_idle("base");
    chk("base_done_pulses", 64'(done_cnt - d0), 1);
    chk("base_queue", 64'(exp_q.size()), 0);

    // Saturation/shift table, one single-pixel frame per record
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{data: 32'(sat_tab[i].pix), keep: 4'h1, last: 1'b1});
      start_frame(1, 1, int'(sat_tab[i].shift));
      send_px(sat_tab[i].csum);
      wait_idle("sat");
    end
    chk("sat_done_pulses", 64'(done_cnt - d0), 8);
    chk("sat_queue", 64'(exp_q.size()), 0);

    // Backpressure: 16 words queued with ready low
    m_axis_ready = 1'b0;
    start_frame(1078, 1, 0);
    for (int w = 0; w < 16; w++)
      exp_q.push_back('{data: {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, keep: 4'hF, last: 1'b0});
    for (int i = 0; i < 44; i++) send_px(32'(i));
    repeat (4) tick();
    chk("pause_at_11", 64'(pause), 0);
    for (int i = 44; i < 48; i++) send_px(32'(i));
    repeat (4) tick();
    chk("pause_at_12", 64'(pause), 1);
    for (int i = 48; i < 64; i++) send_px(32'(i));
    repeat (4) tick();
    chk("bp_no_overflow", 64'(overflow_err), 0);
    m_axis_ready = 1'b1;
    wait_empty("bp");
    repeat (3) tick();
    chk("bp_pause_released", 64'(pause), 0);
    chk("bp_no_overflow_end", 64'(overflow_err), 0);
    pulse_rst();

    // Overflow: 20 words into a 16-deep FIFO, then realignment
    m_axis_ready = 1'b0;
    start_frame(1078, 1, 0);
    for (int w = 0; w < 16; w++)
      exp_q.push_back('{data: {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, keep: 4'hF, last: 1'b0});
    for (int i = 0; i < 80; i++) send_px(32'(i));
    repeat (4) tick();
    chk("ovf_set", 64'(overflow_err), 1);
    m_axis_ready = 1'b1;
    wait_empty("ovf");
    exp_q.push_back('{data: 32'h53525150, keep: 4'hF, last: 1'b0});
    for (int i = 80; i < 84; i++) send_px(32'(i));
    repeat (6) tick();
    wait_empty("ovf_realign");
    pulse_rst();
    chk("rst_clears_ovf", 64'(overflow_err), 0);

    // Reset mid-frame with a word queued
    m_axis_ready = 1'b0;
    start_frame(6, 2, 0);
    for (int i = 0; i < 7; i++) send_px(32'(i + 16));
    Rst = 1'b1;
    tick();
    chk("midrst_valid", 64'(m_axis_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    Rst = 1'b0;
    m_axis_ready = 1'b1;
    exp_q.push_back('{data: 32'h04030201, keep: 4'hF, last: 1'b1});
    d0 = done_cnt;
    start_frame(4, 1, 0);
    for (int i = 1; i <= 4; i++) send_px(32'(i));
    wait_idle("post_rst");
    chk("post_rst_done", 64'(done_cnt - d0), 1);
    chk("post_rst_queue", 64'(exp_q.size()), 0);

    // Zero dimension and spurious input in IDLE
    start_frame(5, 0, 0);
    chk("cfg_err_set", 64'(cfg_err), 1);
    chk("cfg_err_busy", 64'(busy), 0);
    chk("cfg_no_ovf", 64'(overflow_err), 0);
    send_px(32'd77);
    repeat (6) tick();
    chk("idle_px_ovf", 64'(overflow_err), 1);
    chk("idle_px_no_word", 64'(m_axis_valid), 0);
    chk("cfg_err_sticky", 64'(cfg_err), 1);
    pulse_rst();
    chk("rst_clears_flags", {overflow_err, cfg_err}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
